// File: rtl/ones_expander.sv
`default_nettype none
// ============================================================================
// Module   : ones_expander
// Purpose  : Sequential count-to-thermometer converter. A request carrying
//            a ones count is accepted in IDLE. The word is then built one
//            bit position per clock, over WIDTH clocks, and published on q
//            with a one-cycle valid pulse.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            load   - request, sampled only while ready=1
//            cnt    - requested number of ones (legal 0..WIDTH)
//            ready  - high in IDLE (combinational from state)
//            q      - last completed thermometer word (registered)
//            valid  - one-cycle pulse when q updates (registered)
//            err    - last accepted cnt exceeded WIDTH (registered)
// Revision : 1.0 - initial release
// ============================================================================
module ones_expander #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load,
   input  logic [$clog2(WIDTH):0]     cnt,
   output logic                       ready,
   output logic [WIDTH-1:0]           q,
   output logic                       valid,
   output logic                       err
);

   localparam int CW = $clog2(WIDTH) + 1;   // count width
   localparam int IW = $clog2(WIDTH);       // bit-index width

   localparam logic [IW-1:0] c_LAST  = IW'(WIDTH - 1);
   localparam logic [CW-1:0] c_WIDTH = CW'(WIDTH);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_FILL = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [IW-1:0]    r_idx;
   logic [WIDTH-1:0] r_work;

   logic             w_accept;
   logic             w_done;
   logic             w_bit;
   logic [IW-1:0]    w_pos;
   logic [CW-1:0]    w_cnt_clamp;
   logic [WIDTH-1:0] w_work_nxt;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state and handshake decode
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      ready       = 1'b0;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready    = 1'b1;
            w_accept = load;
            if (load) begin
               w_state_nxt = S_FILL;
            end
         end
         S_FILL: begin
            w_done = (r_idx == c_LAST);
            if (w_done) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Bit builder: the index is widened to the count width so that a
   // count of exactly WIDTH sets every position without wrap-around.
   // ---------------------------------------------------------------------
   always_comb begin
      w_cnt_clamp = (cnt > c_WIDTH) ? c_WIDTH : cnt;
      w_bit       = (CW'(r_idx) < r_cnt);
      w_pos       = LSB_FIRST ? r_idx : (c_LAST - r_idx);
      w_work_nxt  = r_work;
      w_work_nxt[w_pos] = w_bit;
   end

   // ---------------------------------------------------------------------
   // Datapath and output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_idx  <= '0;
         r_work <= '0;
         q      <= '0;
         valid  <= 1'b0;
         err    <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (w_accept) begin
            r_cnt  <= w_cnt_clamp;
            err    <= (cnt > c_WIDTH);
            r_work <= '0;
            r_idx  <= '0;
         end else if (r_state == S_FILL) begin
            r_work <= w_work_nxt;
            if (w_done) begin
               // Publish the completed word including the bit written now.
               q     <= w_work_nxt;
               valid <= 1'b1;
            end else begin
               r_idx <= r_idx + IW'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire
